// File: rtl/cla_seq_pkg.sv
// rtl/cla_seq_pkg.sv - shared types and constants for the nibble-serial CLA sequencer
package cla_seq_pkg;

    localparam int SLICE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int slice_cnt(input int width);
        return width / SLICE_W;
    endfunction

endpackage

// File: rtl/carry_lookahead_4bit.sv
// rtl/carry_lookahead_4bit.sv - 4-bit carry-lookahead adder slice
module carry_lookahead_4bit (
    output logic [3:0] SUM,
    output logic       C_out,
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       C_in
);

    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    assign g = A & B;
    assign p = A ^ B;

    // Every carry is expanded from generate/propagate terms, not rippled.
    assign c[0] = C_in;
    assign c[1] = g[0] | (p[0] & C_in);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & C_in);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & C_in);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & C_in);

    assign SUM   = p ^ c[3:0];
    assign C_out = c[4];

endmodule

// File: rtl/cla_slice_sequencer.sv
// rtl/cla_slice_sequencer.sv - wide adder built by sequencing one 4-bit CLA slice per cycle
module cla_slice_sequencer
    import cla_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf
);

    localparam int NSLICE = slice_cnt(WIDTH);
    localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

    state_t state;
    logic [IDX_W-1:0] idx;
    logic carry;
    // Operands and sum are held nibble-indexed so the slice select is a plain mux.
    logic [NSLICE-1:0][SLICE_W-1:0] a_reg;
    logic [NSLICE-1:0][SLICE_W-1:0] b_reg;
    logic [NSLICE-1:0][SLICE_W-1:0] sum_reg;
    logic c_out_reg;
    logic ovf_reg;

    logic [SLICE_W-1:0] slice_sum;
    logic slice_cout;
    logic a_msb;
    logic b_msb;

    carry_lookahead_4bit u_slice (
        .SUM   (slice_sum),
        .C_out (slice_cout),
        .A     (a_reg[idx]),
        .B     (b_reg[idx]),
        .C_in  (carry)
    );

    assign a_msb = a_reg[NSLICE-1][SLICE_W-1];
    assign b_msb = b_reg[NSLICE-1][SLICE_W-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            carry     <= 1'b0;
            a_reg     <= '0;
            b_reg     <= '0;
            sum_reg   <= '0;
            c_out_reg <= 1'b0;
            ovf_reg   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg <= a;
                        b_reg <= b;
                        carry <= c_in;
                        idx   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    sum_reg[idx] <= slice_sum;
                    carry        <= slice_cout;
                    if (idx == LAST_IDX) begin
                        c_out_reg <= slice_cout;
                        ovf_reg   <= (a_msb == b_msb) && (slice_sum[SLICE_W-1] != a_msb);
                        idx       <= '0;
                        state     <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign sum       = sum_reg;
    assign c_out     = c_out_reg;
    assign ovf       = ovf_reg;

endmodule

// File: doc/cla_slice_sequencer.md
# cla_slice_sequencer

Multi-cycle wide adder front end that drives a single `carry_lookahead_4bit` instance one nibble per cycle. It accepts WIDTH-bit operands over a valid/ready handshake and sequences them LSB-nibble-first through the 4-bit carry-lookahead slice. Between slices it registers the ripple carry and assembles the WIDTH-bit sum, carry-out and signed-overflow flag, then presents the result on an output valid/ready handshake. It sits directly upstream of the 4-bit adder, feeding it operands and carry-in, and consumes its SUM/C_out every cycle.

## Interface
- `WIDTH`, default 16: operand width; must be a multiple of 4, minimum 4.
- `NSLICE`, derived, WIDTH/4: number of slice cycles.

- `clk`  in  1  single clock; all state on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  operands valid.
- `in_ready`  out  1  block can accept; equals (state==IDLE).
- `a`  in  WIDTH  operand A.
- `b`  in  WIDTH  operand B.
- `c_in`  in  1  carry into bit 0.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  downstream accepts the result.
- `sum`  out  WIDTH  a+b+c_in mod 2^WIDTH.
- `c_out`  out  1  carry out of bit WIDTH-1.
- `ovf`  out  1  signed (two's complement) overflow.

## Operation
- States:
  - IDLE: `in_ready`=1.
  - RUN: one slice per cycle, index `idx` 0..NSLICE-1.
  - DONE: `out_valid`=1.
- IDLE→RUN on `in_valid`&`in_ready`. On that edge:
  - latch `a`, `b` into operand registers.
  - carry register ← `c_in`, `idx` ← 0.
- RUN, each cycle, the slice inputs are:
  - A = a_reg[4*idx+3:4*idx]
  - B = b_reg[4*idx+3:4*idx]
  - C_in = carry register.
- RUN, on each edge:
  - sum_reg[4*idx+3:4*idx] ← SUM.
  - carry register ← C_out.
  - `idx` ← `idx`+1.
- RUN→DONE on the edge where `idx`==NSLICE-1. On that edge:
  - `c_out` ← slice C_out.
  - `ovf` ← (a_reg[MSB]==b_reg[MSB]) & (SUM[3]!=a_reg[MSB]).
- DONE→IDLE on `out_valid`&`out_ready`.
- `sum`, `c_out` and `ovf` hold their values until the next result is written. They are not cleared on handshake.
- `in_valid` is ignored outside IDLE. Operand inputs are sampled only at the accept edge, so upstream may change them afterwards.
- Arithmetic is unsigned modulo 2^WIDTH. `ovf` applies the signed interpretation only.
- Boundary cases:
  - all-ones + 1 wraps to 0 with `c_out`=1.
  - `c_in`=1 with all-ones + 0 gives 0 with `c_out`=1.
- Reset (asynchronous, any state including mid-RUN) forces:
  - state=IDLE, so `in_ready`=1.
  - `out_valid`=0, `sum`=0, `c_out`=0, `ovf`=0.
  - carry register=0, `idx`=0.
  - Any partial result is discarded.

## Timing
- Accept edge = E0. Slice k is evaluated in the cycle after edge E0+k, for k=0..NSLICE-1.
- `out_valid` rises after edge E0+NSLICE. Accept-to-valid latency is NSLICE cycles: 4 for WIDTH=16.
- Minimum issue interval is NSLICE+2 cycles: NSLICE RUN cycles, one DONE cycle with immediate `out_ready`, and one IDLE cycle. No accept occurs in the same cycle as result handoff.
- `out_ready` low in DONE: stay in DONE indefinitely with outputs stable.
- The combinational path is register → carry_lookahead_4bit → register. The ovf compare adds one XOR level on the last slice only.

## Structure
- Package `cla_seq_pkg`:
  - `SLICE_W`=4.
  - State enum {IDLE, RUN, DONE}.
  - Helper function `slice_cnt(width)`.
- One sub-module: a single instance of the existing `carry_lookahead_4bit`.
  - Port order is (SUM, C_out, A, B, C_in).
  - Its C_in must be driven from the carry register, never tied to its own C_out.
- Slice index counter width is $clog2(NSLICE) with a minimum of 1.

## Test plan
- 0x0007 + 0x0003, c_in=0 → sum=0x000A, c_out=0, ovf=0; `out_valid` rises exactly 4 cycles after accept.
- 0xFFFF + 0x0001, c_in=0 → sum=0x0000, c_out=1, ovf=0. Also 0xFFFF + 0x0000, c_in=1 → same result.
- 0x7FFF + 0x0001 → sum=0x8000, c_out=0, ovf=1; 0x8000 + 0x8000 → sum=0x0000, c_out=1, ovf=1.
- 0x00F8 + 0x0F08 (carry ripples across nibbles 0→1→2) → sum=0x1000, c_out=0. Hold `out_ready`=0 for 3 cycles: `out_valid` and `sum` stay stable and `in_ready`=0 throughout.
- Pulse `in_valid` during RUN with different operands → ignored; result still matches the originally accepted pair.
- Assert `rst_n`=0 for one cycle during slice 2 → immediately `out_valid`=0, `sum`=0, `in_ready`=1. A subsequent 0x1234 + 0x1111 yields 0x2345.
